multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Sequencing FSM for the multi-cycle RV32I-subset core. It steps each instruction through FETCH, DECODE, EXECUTE, MEM and WB, and drives the datapath enables. It also handshakes with a single shared, variable-latency instruction/data memory port. It covers the same opcode subset and ALUOp encoding as the single-cycle decoder, and adds illegal-instruction and memory-timeout trapping.

## Interface
- `MEM_TIMEOUT`, default 15: maximum wait cycles for `mem_ready` per request; 0 disables the watchdog.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `opcode`  in  7  from the instruction register; valid from DECODE onward.
- `funct3`  in  3  from the instruction register.
- `funct7`  in  7  from the instruction register.
- `zero`  in  1  ALU zero flag; sampled in EXECUTE for branches.
- `mem_ready`  in  1  memory accepts or completes the current request.
- `mem_req`  out  1  memory request, held until accepted.
- `mem_we`  out  1  write request (store).
- `mem_addr_sel`  out  1  memory address source: 0 = PC, 1 = ALU result.
- `ir_write`  out  1  load the IR and the old-PC register.
- `pc_write`  out  1  update the PC.
- `pc_src`  out  1  PC source: 0 = PC+4, 1 = branch target (old PC + immediate).
- `reg_write`  out  1  register file write.
- `mem_to_reg`  out  1  writeback source: 0 = ALU, 1 = memory data.
- `alu_src`  out  1  ALU B operand: 0 = rs2, 1 = immediate.
- `alu_op`  out  4  ALU operation code.
- `instr_retired`  out  1  one-cycle pulse when an instruction completes.
- `trap`  out  1  sticky trap flag.
- `trap_cause`  out  2  01 = illegal instruction, 10 = memory timeout.
- `state`  out  3  current state, for debug.

## Operation
- State encoding: FETCH = 0, DECODE = 1, EXECUTE = 2, MEM = 3, WB = 4, TRAP = 5.
- ALUOp codes: ADD 0000, SUB 0001, AND 0010, OR 0011, SRL 0110, ANDI 1010.
- **FETCH**
  - Outputs: `mem_req` = 1, `mem_addr_sel` = 0.
  - The state holds until `mem_ready` = 1.
  - In the `mem_ready` cycle: `ir_write` = 1, `pc_write` = 1, `pc_src` = 0, then go to DECODE.
- **DECODE**
  - One cycle; classifies the opcode and funct fields.
  - Illegal encoding: go to TRAP with cause 01. Otherwise go to EXECUTE.
- **Legal encodings**
  - R-type: ADD, SUB, OR, AND, SRL.
  - I-ALU: ADDI, ANDI.
  - Load: funct3 = 010 (LW).
  - Store: funct3 = 010 (SW).
  - Branch: funct3 = 000 (BEQ) or 001 (BNE).
- **EXECUTE**
  - `alu_src` and `alu_op` are set per instruction class. Load and store use ADD with `alu_src` = 1.
  - R-type and I-ALU go to WB.
  - Load and store go to MEM.
  - Branch: `alu_op` = SUB, `alu_src` = 0. If the condition holds (BEQ: `zero`; BNE: !`zero`), assert `pc_write` = 1 and `pc_src` = 1. Then `instr_retired` pulses and the FSM goes to FETCH.
- **MEM**
  - Outputs: `mem_req` = 1, `mem_addr_sel` = 1, `mem_we` = 1 for stores.
  - The state holds until `mem_ready` = 1.
  - Store completes: `instr_retired` pulses, go to FETCH.
  - Load completes: go to WB.
- **WB**
  - `reg_write` = 1; `mem_to_reg` = 1 for loads.
  - `instr_retired` pulses, then go to FETCH.
- **TRAP**
  - All enables are 0; `trap` = 1 and `trap_cause` is held.
  - The FSM stays in TRAP until `rst`.
- **Watchdog**
  - The wait counter clears on entry to FETCH or MEM and increments each cycle that `mem_req` = 1 and `mem_ready` = 0.
  - When the counter reaches `MEM_TIMEOUT`: go to TRAP with cause 10, and drop `mem_req` the next cycle.
- Sub-encodings that are not legal never produce an ALUOp. They trap; there is no silent default.

## Timing
- **Reset**
  - While `rst` = 1, every output is 0 and `state` = FETCH.
  - The first cycle after release drives `mem_req` = 1.
- **Output types**
  - State-decoded (Moore) outputs: all outputs not listed below.
  - Outputs that also depend on inputs: `ir_write`, `pc_write`, `instr_retired` on the store path, and the branch `pc_write`.
- **Memory handshake**
  - A transfer occurs in a cycle with `mem_req` = 1 and `mem_ready` = 1.
  - `mem_ready` is ignored when `mem_req` = 0.
  - Address and `mem_we` are stable while `mem_req` is held.
- **Latency with zero-wait memory** (each memory wait state adds 1 cycle):
  - Branch: 3 cycles.
  - R-type, I-ALU, store: 4 cycles.
  - Load: 5 cycles.
- **Simultaneous timeout and ready:** if `mem_ready` arrives in the same cycle the counter would reach `MEM_TIMEOUT`, the transfer completes and no trap is raised.
- **Reset mid-operation:** the instruction is abandoned and `mem_req` is 0 from the cycle `rst` is sampled. The memory must tolerate a withdrawn request.

## Configuration
- Macro `MC_PERF_CNT_EN`.
- **When defined:**
  - Adds output `cycle_cnt[31:0]`: increments every cycle outside reset and outside TRAP.
  - Adds output `instret_cnt[31:0]`: increments on each `instr_retired`.
  - Both counters reset to 0 and wrap modulo 2^32.
- **When undefined:** the ports and logic are absent, and behaviour is otherwise identical.

## Structure
- Package `riscv_pkg` holds:
  - opcode constants (0110011, 0000011, 0010011, 0100011, 1100011);
  - the ALUOp code constants;
  - the state encoding;
  - the trap-cause codes.
- Sub-module `alu_op_decoder`: combinational. Maps opcode/funct3/funct7 to class, `alu_op` and an illegal flag; used in DECODE and EXECUTE.

## Test plan
- **ADD:** `mem_ready` tied to 1, IR = ADD (0110011/000/0000000) → states 0,1,2,4,0; `reg_write` in WB; `alu_op` = 0000; `instr_retired` on cycle 4.
- **LW with waits:** 3 wait states in FETCH and 2 in MEM → `mem_addr_sel` = 0 then 1; `mem_to_reg` = 1; total latency 10 cycles; `mem_req` continuous during waits.
- **Branches:** BEQ with `zero` = 1 → `pc_write` = 1 and `pc_src` = 1 in EXECUTE. BNE with `zero` = 1 → `pc_write` = 0. Both retire on cycle 3.
- **Illegal instruction:** IR = 0110011/001/0000000 (SLL) → TRAP after DECODE, `trap_cause` = 01, all enables 0 until `rst`.
- **Memory timeout:** `mem_ready` held 0 with `MEM_TIMEOUT` = 15 → TRAP with cause 10 after 15 waiting cycles. With `mem_ready` rising in that same cycle → no trap.
- **Reset mid-operation:** `rst` in MEM of a store → `mem_req` = 0 and `state` = FETCH; with `MC_PERF_CNT_EN`, both counters read 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared constants for the multi-cycle RV32I-subset controller: opcodes,
// ALUOp codes, FSM state encoding and trap causes.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_ANDI = 4'b1010;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_TRAP    = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CLS_R, CLS_IMM, CLS_LOAD, CLS_STORE, CLS_BRANCH
  } iclass_t;

  localparam logic [1:0] TRAP_NONE        = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL     = 2'b01;
  localparam logic [1:0] TRAP_MEM_TIMEOUT = 2'b10;

endpackage

// File: rtl/multicycle_controller_if.sv
// Shared instruction/data memory handshake; the controller is the master.
interface multicycle_controller_if;
  logic mem_req;
  logic mem_we;
  logic mem_addr_sel;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output mem_addr_sel, input mem_ready);
  modport slave  (input mem_req, input mem_we, input mem_addr_sel, output mem_ready);
endinterface

// File: rtl/alu_op_decoder.sv
// Combinational instruction classifier: opcode/funct3/funct7 -> class, ALUOp,
// illegal flag. Any sub-encoding outside the supported subset is illegal.
module alu_op_decoder
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output iclass_t    iclass,
  output logic [3:0] alu_op,
  output logic       illegal
);

  always_comb begin
    iclass  = CLS_R;
    alu_op  = ALU_ADD;
    illegal = 1'b0;
    case (opcode)
      OP_R: begin
        iclass = CLS_R;
        case ({funct7, funct3})
          {7'b0000000, 3'b000}: alu_op = ALU_ADD;
          {7'b0100000, 3'b000}: alu_op = ALU_SUB;
          {7'b0000000, 3'b111}: alu_op = ALU_AND;
          {7'b0000000, 3'b110}: alu_op = ALU_OR;
          {7'b0000000, 3'b101}: alu_op = ALU_SRL;
          default:              illegal = 1'b1;
        endcase
      end
      OP_IMM: begin
        // funct7 carries immediate bits here, so it is not decoded
        iclass = CLS_IMM;
        case (funct3)
          3'b000:  alu_op = ALU_ADD;
          3'b111:  alu_op = ALU_ANDI;
          default: illegal = 1'b1;
        endcase
      end
      OP_LOAD: begin
        iclass  = CLS_LOAD;
        illegal = (funct3 != 3'b010);
      end
      OP_STORE: begin
        iclass  = CLS_STORE;
        illegal = (funct3 != 3'b010);
      end
      OP_BRANCH: begin
        iclass  = CLS_BRANCH;
        alu_op  = ALU_SUB;
        illegal = (funct3[2:1] != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle sequencing FSM with memory handshake, illegal/timeout traps.
// Optional performance counters are built when MC_PERF_CNT_EN is defined.
module multicycle_controller
  import riscv_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  multicycle_controller_if.master mem,
  input  logic [6:0]              opcode,
  input  logic [2:0]              funct3,
  input  logic [6:0]              funct7,
  input  logic                    zero,
  output logic                    ir_write,
  output logic                    pc_write,
  output logic                    pc_src,
  output logic                    reg_write,
  output logic                    mem_to_reg,
  output logic                    alu_src,
  output logic [3:0]              alu_op,
  output logic                    instr_retired,
  output logic                    trap,
  output logic [1:0]              trap_cause,
`ifdef MC_PERF_CNT_EN
  output logic [31:0]             cycle_cnt,
  output logic [31:0]             instret_cnt,
`endif
  output logic [2:0]              state
);

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(MEM_TIMEOUT - 1);

  state_t        st;
  iclass_t       iclass;
  logic [3:0]    dec_alu_op;
  logic          illegal;
  logic [CW-1:0] wait_cnt;
  logic          trap_q;
  logic [1:0]    cause_q;
  logic          waiting, timeout, taken;

  alu_op_decoder u_dec (
    .opcode  (opcode),
    .funct3  (funct3),
    .funct7  (funct7),
    .iclass  (iclass),
    .alu_op  (dec_alu_op),
    .illegal (illegal)
  );

  // Ready wins over timeout: the watchdog only fires on a cycle still waiting.
  assign waiting = ((st == S_FETCH) || (st == S_MEM)) && !mem.mem_ready;
  assign timeout = waiting && (MEM_TIMEOUT != 0) && (wait_cnt == TO_LAST);
  assign taken   = zero ^ funct3[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= S_FETCH;
      wait_cnt <= '0;
      trap_q   <= 1'b0;
      cause_q  <= TRAP_NONE;
    end else begin
      wait_cnt <= waiting ? wait_cnt + 1'b1 : '0;
      case (st)
        S_FETCH:
          if (mem.mem_ready) st <= S_DECODE;
          else if (timeout) begin
            st <= S_TRAP; trap_q <= 1'b1; cause_q <= TRAP_MEM_TIMEOUT;
          end
        S_DECODE:
          if (illegal) begin
            st <= S_TRAP; trap_q <= 1'b1; cause_q <= TRAP_ILLEGAL;
          end else st <= S_EXECUTE;
        S_EXECUTE:
          if (iclass == CLS_LOAD || iclass == CLS_STORE) st <= S_MEM;
          else if (iclass == CLS_BRANCH)                 st <= S_FETCH;
          else                                           st <= S_WB;
        S_MEM:
          if (mem.mem_ready) st <= (iclass == CLS_STORE) ? S_FETCH : S_WB;
          else if (timeout) begin
            st <= S_TRAP; trap_q <= 1'b1; cause_q <= TRAP_MEM_TIMEOUT;
          end
        S_WB:    st <= S_FETCH;
        default: st <= S_TRAP;
      endcase
    end
  end

  // Outputs decode the registered state; rst forces them low immediately so a
  // withdrawn request is visible in the very cycle reset is applied.
  always_comb begin
    mem.mem_req      = 1'b0;
    mem.mem_we       = 1'b0;
    mem.mem_addr_sel = 1'b0;
    ir_write         = 1'b0;
    pc_write         = 1'b0;
    pc_src           = 1'b0;
    reg_write        = 1'b0;
    mem_to_reg       = 1'b0;
    alu_src          = 1'b0;
    alu_op           = ALU_ADD;
    instr_retired    = 1'b0;
    if (!rst) begin
      case (st)
        S_FETCH: begin
          mem.mem_req = 1'b1;
          ir_write    = mem.mem_ready;
          pc_write    = mem.mem_ready;
        end
        S_EXECUTE: begin
          alu_op  = dec_alu_op;
          alu_src = (iclass == CLS_IMM) || (iclass == CLS_LOAD) || (iclass == CLS_STORE);
          if (iclass == CLS_BRANCH) begin
            pc_src        = 1'b1;
            pc_write      = taken;
            instr_retired = 1'b1;
          end
        end
        S_MEM: begin
          mem.mem_req      = 1'b1;
          mem.mem_addr_sel = 1'b1;
          mem.mem_we       = (iclass == CLS_STORE);
          instr_retired    = (iclass == CLS_STORE) && mem.mem_ready;
        end
        S_WB: begin
          reg_write     = 1'b1;
          mem_to_reg    = (iclass == CLS_LOAD);
          instr_retired = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign trap       = trap_q && !rst;
  assign trap_cause = rst ? TRAP_NONE : cause_q;
  assign state      = rst ? S_FETCH : st;

`ifdef MC_PERF_CNT_EN
  logic [31:0] cyc_q, ret_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      if (st != S_TRAP) cyc_q <= cyc_q + 32'd1;
      if (instr_retired) ret_q <= ret_q + 32'd1;
    end
  end

  assign cycle_cnt   = rst ? '0 : cyc_q;
  assign instret_cnt = rst ? '0 : ret_q;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: a vector table of single
// instructions with zero-wait memory plus hand sequences for waits, timeouts and reset.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic [6:0] funct7 = '0;
  logic       zero = 1'b0;
  logic       ir_write, pc_write, pc_src, reg_write, mem_to_reg, alu_src;
  logic [3:0] alu_op;
  logic       instr_retired, trap;
  logic [1:0] trap_cause;
  logic [2:0] state;
`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  multicycle_controller_if mem ();

  multicycle_controller #(.MEM_TIMEOUT(15)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem           (mem.master),
    .opcode        (opcode),
    .funct3        (funct3),
    .funct7        (funct7),
    .zero          (zero),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .pc_src        (pc_src),
    .reg_write     (reg_write),
    .mem_to_reg    (mem_to_reg),
    .alu_src       (alu_src),
    .alu_op        (alu_op),
    .instr_retired (instr_retired),
    .trap          (trap),
    .trap_cause    (trap_cause),
`ifdef MC_PERF_CNT_EN
    .cycle_cnt     (cycle_cnt),
    .instret_cnt   (instret_cnt),
`endif
    .state         (state)
  );

  always #5 clk = ~clk;

  logic [13:0] en;
  assign en = {mem.mem_req, mem.mem_we, mem.mem_addr_sel, ir_write, pc_write, pc_src,
               reg_write, mem_to_reg, alu_src, alu_op, instr_retired};

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem.mem_ready = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic set_ir(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
    opcode = o; funct3 = f3; funct7 = f7;
  endtask

  typedef struct packed {
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       z;
    logic [3:0] lat;
    logic [3:0] aop;
    logic       asrc, pcw, rw, m2r, we, trp;
    logic [1:0] cause;
  } vec_t;

  localparam int NV = 22;
  vec_t vt [NV];

  vec_t       v;
  logic [3:0] o_lat, o_aop;
  logic       o_asrc, o_pcw, o_rw, o_m2r, o_we, o_trp;
  logic [1:0] o_cause;
  int         ret;

  initial begin
    //         opc         f3      f7          z     lat   aop      src   pcw   rw    m2r   we    trp   cause
    vt[0]  = '{7'b0110011, 3'b000, 7'b0000000, 1'b0, 4'd4, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00}; // ADD
    vt[1]  = '{7'b0110011, 3'b000, 7'b0100000, 1'b0, 4'd4, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00}; // SUB
    vt[2]  = '{7'b0110011, 3'b111, 7'b0000000, 1'b0, 4'd4, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00}; // AND
    vt[3]  = '{7'b0110011, 3'b110, 7'b0000000, 1'b0, 4'd4, 4'b0011, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00}; // OR
    vt[4]  = '{7'b0110011, 3'b101, 7'b0000000, 1'b0, 4'd4, 4'b0110, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00}; // SRL
    vt[5]  = '{7'b0010011, 3'b000, 7'b0101010, 1'b0, 4'd4, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00}; // ADDI
    vt[6]  = '{7'b0010011, 3'b111, 7'b1111111, 1'b0, 4'd4, 4'b1010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00}; // ANDI
    vt[7]  = '{7'b0000011, 3'b010, 7'b0000000, 1'b0, 4'd5, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00}; // LW
    vt[8]  = '{7'b0100011, 3'b010, 7'b0000000, 1'b0, 4'd4, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00}; // SW
    vt[9]  = '{7'b1100011, 3'b000, 7'b0000000, 1'b1, 4'd3, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00}; // BEQ taken
    vt[10] = '{7'b1100011, 3'b000, 7'b0000000, 1'b0, 4'd3, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00}; // BEQ not taken
    vt[11] = '{7'b1100011, 3'b001, 7'b0000000, 1'b1, 4'd3, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00}; // BNE not taken
    vt[12] = '{7'b1100011, 3'b001, 7'b0000000, 1'b0, 4'd3, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00}; // BNE taken
    vt[13] = '{7'b0110011, 3'b001, 7'b0000000, 1'b0, 4'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01}; // SLL
    vt[14] = '{7'b0110011, 3'b101, 7'b0100000, 1'b0, 4'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01}; // SRA
    vt[15] = '{7'b0110011, 3'b000, 7'b0000001, 1'b0, 4'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01}; // MUL
    vt[16] = '{7'b0000011, 3'b000, 7'b0000000, 1'b0, 4'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01}; // LB
    vt[17] = '{7'b0100011, 3'b001, 7'b0000000, 1'b0, 4'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01}; // SH
    vt[18] = '{7'b1100011, 3'b100, 7'b0000000, 1'b0, 4'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01}; // BLT
    vt[19] = '{7'b0010011, 3'b110, 7'b0000000, 1'b0, 4'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01}; // ORI
    vt[20] = '{7'b1111111, 3'b000, 7'b0000000, 1'b0, 4'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01}; // bad opcode
    vt[21] = '{7'b0110011, 3'b111, 7'b0100000, 1'b0, 4'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01}; // AND w/ funct7

    mem.mem_ready = 1'b1;

    // Reset state: everything low while rst is held, request on first cycle after release
    set_ir(7'b0110011, 3'b000, 7'b0000000);
    rst = 1'b1;
    step();
    @(negedge clk);
    check("rst_enables", 32'(en), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    check("rst_trap", 32'({trap, trap_cause}), 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("first_mem_req", 32'(mem.mem_req), 32'd1);
    step();

    // Vector table, zero-wait memory
    for (int i = 0; i < NV; i++) begin
      v = vt[i];
      set_ir(v.opc, v.f3, v.f7);
      zero = v.z;
      do_reset();
      o_lat = '0; o_aop = '0; o_asrc = 0; o_pcw = 0; o_rw = 0; o_m2r = 0; o_we = 0;
      o_trp = 0; o_cause = '0;
      for (int c = 1; c <= 6; c++) begin
        @(negedge clk);
        if (o_lat == 0) begin
          if (state == 3'd2) begin
            o_aop = alu_op; o_asrc = alu_src; o_pcw = pc_write;
          end
          o_rw  = o_rw  | reg_write;
          o_m2r = o_m2r | mem_to_reg;
          o_we  = o_we  | mem.mem_we;
          if (instr_retired) o_lat = 4'(c);
        end
        if (trap) begin
          o_trp = 1'b1; o_cause = trap_cause;
        end
        step();
      end
      check($sformatf("vec%0d_latency", i), 32'(o_lat), 32'(v.lat));
      check($sformatf("vec%0d_alu_op", i), 32'(o_aop), 32'(v.aop));
      check($sformatf("vec%0d_alu_src", i), 32'(o_asrc), 32'(v.asrc));
      check($sformatf("vec%0d_br_pc_write", i), 32'(o_pcw), 32'(v.pcw));
      check($sformatf("vec%0d_reg_write", i), 32'(o_rw), 32'(v.rw));
      check($sformatf("vec%0d_mem_to_reg", i), 32'(o_m2r), 32'(v.m2r));
      check($sformatf("vec%0d_mem_we", i), 32'(o_we), 32'(v.we));
      check($sformatf("vec%0d_trap", i), 32'(o_trp), 32'(v.trp));
      check($sformatf("vec%0d_trap_cause", i), 32'(o_cause), 32'(v.cause));
    end
    zero = 1'b0;

    // LW with 3 fetch waits and 2 mem waits: states 0,0,0,0,1,2,3,3,3,4
    set_ir(7'b0000011, 3'b010, 7'b0000000);
    do_reset();
    ret = 0;
    for (int c = 1; c <= 10; c++) begin
      mem.mem_ready = !(c inside {1, 2, 3, 7, 8});
      @(negedge clk);
      check($sformatf("lw_state_c%0d", c), 32'(state),
            (c <= 4) ? 32'd0 : (c == 5) ? 32'd1 : (c == 6) ? 32'd2 : (c <= 9) ? 32'd3 : 32'd4);
      check($sformatf("lw_mem_req_c%0d", c), 32'(mem.mem_req),
            32'((c <= 4) || (c >= 7 && c <= 9)));
      if (mem.mem_req) check($sformatf("lw_addr_sel_c%0d", c), 32'(mem.mem_addr_sel), 32'(c >= 7));
      check($sformatf("lw_ir_write_c%0d", c), 32'(ir_write), 32'(c == 4));
      if (c == 10) check("lw_mem_to_reg", 32'(mem_to_reg), 32'd1);
      if (instr_retired && ret == 0) ret = c;
      step();
    end
    check("lw_wait_latency", 32'(ret), 32'd10);

    // FETCH timeout: 15 waiting cycles, then TRAP with cause 10
    set_ir(7'b0110011, 3'b000, 7'b0000000);
    do_reset();
    mem.mem_ready = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 15) begin
        check("fto_state_c15", 32'(state), 32'd0);
        check("fto_req_c15", 32'(mem.mem_req), 32'd1);
      end
      if (c == 16) begin
        check("fto_state_c16", 32'(state), 32'd5);
        check("fto_req_dropped", 32'(mem.mem_req), 32'd0);
        check("fto_trap", 32'({trap, trap_cause}), 32'b110);
      end
      step();
    end
    mem.mem_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("fto_hold_en%0d", c), 32'(en), 32'd0);
      check($sformatf("fto_hold_state%0d", c), 32'(state), 32'd5);
      step();
    end

    // Ready arriving on the would-be timeout cycle completes the transfer
    do_reset();
    for (int c = 1; c <= 16; c++) begin
      mem.mem_ready = (c == 15);
      @(negedge clk);
      if (c == 15) check("edge_ir_write", 32'(ir_write), 32'd1);
      if (c == 16) begin
        check("edge_state", 32'(state), 32'd1);
        check("edge_no_trap", 32'(trap), 32'd0);
      end
      step();
    end

    // MEM-phase timeout on a store
    set_ir(7'b0100011, 3'b010, 7'b0000000);
    do_reset();
    for (int c = 1; c <= 19; c++) begin
      mem.mem_ready = (c <= 3);
      @(negedge clk);
      if (c == 18) begin
        check("mto_state_c18", 32'(state), 32'd3);
        check("mto_we_c18", 32'(mem.mem_we), 32'd1);
      end
      if (c == 19) begin
        check("mto_state_c19", 32'(state), 32'd5);
        check("mto_cause", 32'(trap_cause), 32'b10);
      end
      step();
    end

    // Illegal instruction: enables stay 0 in TRAP until reset clears it
    set_ir(7'b0110011, 3'b001, 7'b0000000);
    do_reset();
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c >= 3) begin
        check($sformatf("ill_en_c%0d", c), 32'(en), 32'd0);
        check($sformatf("ill_trap_c%0d", c), 32'({trap, trap_cause}), 32'b101);
      end
      step();
    end
    set_ir(7'b0110011, 3'b000, 7'b0000000);
    do_reset();
    @(negedge clk);
    check("ill_cleared_trap", 32'({trap, trap_cause}), 32'd0);
    check("ill_cleared_state", 32'(state), 32'd0);
    step();

    // Reset in the MEM state of a store withdraws the request
    set_ir(7'b0100011, 3'b010, 7'b0000000);
    do_reset();
    for (int c = 1; c <= 4; c++) begin
      mem.mem_ready = (c <= 3);
      @(negedge clk);
      if (c == 4) check("mid_pre_req", 32'({state, mem.mem_req, mem.mem_we}), 32'b01111);
      step();
    end
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_req", 32'(mem.mem_req), 32'd0);
    check("mid_rst_state", 32'(state), 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("mid_after_state", 32'(state), 32'd0);
`ifdef MC_PERF_CNT_EN
    check("mid_cycle_cnt", cycle_cnt, 32'd0);
    check("mid_instret_cnt", instret_cnt, 32'd0);
`endif
    step();

`ifdef MC_PERF_CNT_EN
    // Two back-to-back ADDs in 8 cycles
    set_ir(7'b0110011, 3'b000, 7'b0000000);
    do_reset();
    for (int c = 1; c <= 8; c++) step();
    @(negedge clk);
    check("perf_cycle_cnt", cycle_cnt, 32'd8);
    check("perf_instret_cnt", instret_cnt, 32'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
